hit_detector: RTL and testbench

//  Player-side counterpart of the light flicker: takes the 9 raw board buttons, debounces them,
//  and judges each press against the currently lit hole. Emits hit/miss pulses and keeps

---
 rtl/hit_detector_pkg.sv | 21 ++
 rtl/hit_detector_button_debouncer.sv | 46 ++++
 rtl/hit_detector.sv | 117 +++++++++++
 tb/tb_hit_detector.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_detector_pkg.sv
// Shared game constants and judge FSM encoding, common to the hit detector and light controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hit_detector_pkg;

  localparam int NUM_HOLES  = 9;
  localparam int HOLE_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } judge_state_t;

  // One-hot mask for a hole index; out-of-range indices select no hole.
  function automatic logic [NUM_HOLES-1:0] hole_mask(input logic [HOLE_IDX_W-1:0] idx);
    hole_mask = '0;
    if (idx < HOLE_IDX_W'(NUM_HOLES)) hole_mask = NUM_HOLES'(1) << idx;
  endfunction

endpackage

// File: rtl/hit_detector_button_debouncer.sv
// Single-button 2-flop synchronizer + stability debouncer + rising-edge press pulse.
// Latency: raw edge -> level/press = 2 + DEBOUNCE_CYCLES cycles.
// Backpressure: none; press is a 1-cycle pulse that is never held.
// Ports: clk, reset (async active-low), raw (async button), level (debounced), press (0->1 pulse).
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic            sync1, sync2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 != level) begin
        // The cycle that completes the run of differing samples flips the level,
        // so the count only has to reach DEBOUNCE_CYCLES-1 before that.
        if (cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          press <= sync2;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hit_detector.sv
// Debounces the 9 board buttons and judges each press against the lit hole; saturating tallies.
// Latency: raw edge -> hit/miss = 3 + DEBOUNCE_CYCLES cycles (press -> hit/miss registered, 1 cycle).
// Backpressure: none; hit/miss are 1-cycle pulses, presses outside ARMED are dropped.
// Ports: clk, reset (async active-low), enable, lights/light_pos (from light controller),
//        buttons (raw), hit/miss pulses, hit_pos, hit_count/miss_count.
module hit_detector
  import hit_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int SCORE_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [NUM_HOLES-1:0]  lights,
  input  logic [HOLE_IDX_W-1:0] light_pos,
  input  logic [NUM_HOLES-1:0]  buttons,
  output logic                  hit,
  output logic                  miss,
  output logic [HOLE_IDX_W-1:0] hit_pos,
  output logic [SCORE_W-1:0]    hit_count,
  output logic [SCORE_W-1:0]    miss_count
);

  logic [NUM_HOLES-1:0] level, press, press_q, wrong;
  logic [NUM_HOLES-1:0] lights_q;
  logic [HOLE_IDX_W-1:0] wrong_idx, pos_nxt;
  logic                  hit_nxt, miss_nxt;
  judge_state_t          state, state_nxt;

  for (genvar i = 0; i < NUM_HOLES; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .DB_W           (DB_W)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (buttons[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  // A press only counts while its debounced level is still asserted.
  assign press_q = press & level;
  assign wrong   = press_q & ~hole_mask(light_pos);

  // Lowest-numbered wrong button is reported when several are pressed together.
  always_comb begin
    wrong_idx = '0;
    for (int i = NUM_HOLES - 1; i >= 0; i--) begin
      if (wrong[i]) wrong_idx = HOLE_IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    pos_nxt   = hit_pos;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (lights != '0) state_nxt = ARMED;
        end
        ARMED: begin
          if (lights == '0) begin
            // Light expired unpressed; a press this same cycle is ignored.
            miss_nxt  = 1'b1;
            state_nxt = IDLE;
          end else if (lights != lights_q) begin
            // Jump straight to a new hole: old flick times out, new one is armed.
            miss_nxt = 1'b1;
          end else if (press_q != '0) begin
            state_nxt = LOCKED;
            if (wrong != '0) begin
              miss_nxt = 1'b1;
              pos_nxt  = wrong_idx;
            end else begin
              hit_nxt = 1'b1;
              pos_nxt = light_pos;
            end
          end
        end
        LOCKED: begin
          if (lights == '0)            state_nxt = IDLE;
          else if (lights != lights_q) state_nxt = ARMED;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      lights_q   <= '0;
      hit        <= 1'b0;
      miss       <= 1'b0;
      hit_pos    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      state    <= state_nxt;
      lights_q <= lights;
      hit      <= hit_nxt;
      miss     <= miss_nxt;
      hit_pos  <= pos_nxt;
      if (hit_nxt && hit_count != '1)   hit_count  <= hit_count + SCORE_W'(1);
      if (miss_nxt && miss_count != '1) miss_count <= miss_count + SCORE_W'(1);
    end
  end

endmodule

// File: tb/tb_hit_detector.sv
module tb_hit_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [8:0] lights;
  logic [3:0] light_pos;
  logic [8:0] buttons;
  logic       hit, miss;
  logic [3:0] hit_pos;
  logic [7:0] hit_count, miss_count;

  int vectors = 0;
  int miscompares = 0;
  int hit_seen = 0;
  int miss_seen = 0;
  int both_seen = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  always #5 clk = ~clk;

  hit_detector #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (3),
    .SCORE_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .lights    (lights),
    .light_pos (light_pos),
    .buttons   (buttons),
    .hit       (hit),
    .miss      (miss),
    .hit_pos   (hit_pos),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always @(negedge clk) begin
    if (hit) hit_seen++;
    if (miss) miss_seen++;
    if (hit && miss) both_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_light(input int p);
    lights    = 9'd1 << p;
    light_pos = 4'(p);
  endtask

  task automatic clear_lights();
    lights    = '0;
    light_pos = '0;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    enable  = 1'b0;
    buttons = '0;
    clear_lights();
    repeat (3) tick();
    reset  = 1'b1;
    enable = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({hit, miss, hit_pos, hit_count, miss_count} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_state: got hit=%0b miss=%0b pos=%0d hc=%0d mc=%0d, want all 0",
               hit, miss, hit_pos, hit_count, miss_count);
    end
  endtask

  // Correct press: hit 7 cycles after the raw edge with DEBOUNCE_CYCLES=4.
  task automatic test_hit();
    int first_k = -1;
    logic [3:0] pos_at = '0;
    logic [7:0] cnt_at = '0;
    int h0 = hit_seen;
    set_light(4);
    tick();
    buttons[4] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (hit === 1'b1 && first_k < 0) begin
        first_k = k;
        pos_at  = hit_pos;
        cnt_at  = hit_count;
      end
    end
    exp_hit++;
    vectors++;
    if (first_k !== 7) begin
      miscompares++;
      $display("FAIL hit_latency: got %0d, want 7", first_k);
    end
    vectors++;
    if (pos_at !== 4'd4) begin
      miscompares++;
      $display("FAIL hit_pos: got %0d, want 4", pos_at);
    end
    vectors++;
    if (cnt_at !== 8'(exp_hit)) begin
      miscompares++;
      $display("FAIL hit_count: got %0d, want %0d", cnt_at, exp_hit);
    end
    vectors++;
    if (hit_seen - h0 !== 1) begin
      miscompares++;
      $display("FAIL hit_single_pulse: got %0d pulses, want 1", hit_seen - h0);
    end
    buttons[4] = 1'b0;
    clear_lights();
    repeat (8) tick();
  endtask

  // Wrong hole pressed, then the correct one is ignored while locked.
  task automatic test_wrong_press();
    int first_k = -1;
    int h0, m0;
    set_light(4);
    tick();
    buttons[2] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (miss === 1'b1 && first_k < 0) first_k = k;
    end
    exp_miss++;
    vectors++;
    if (first_k !== 7) begin
      miscompares++;
      $display("FAIL miss_latency: got %0d, want 7", first_k);
    end
    vectors++;
    if (hit_pos !== 4'd2 || miss_count !== 8'(exp_miss)) begin
      miscompares++;
      $display("FAIL wrong_press: got pos=%0d mc=%0d, want pos=2 mc=%0d", hit_pos, miss_count, exp_miss);
    end
    buttons[2] = 1'b0;
    repeat (8) tick();
    h0 = hit_seen;
    m0 = miss_seen;
    buttons[4] = 1'b1;
    repeat (12) tick();
    vectors++;
    if (hit_seen - h0 !== 0 || miss_seen - m0 !== 0 || hit_count !== 8'(exp_hit)) begin
      miscompares++;
      $display("FAIL locked_ignore: got hits=%0d misses=%0d hc=%0d, want 0 0 %0d",
               hit_seen - h0, miss_seen - m0, hit_count, exp_hit);
    end
    buttons[4] = 1'b0;
    clear_lights();
    repeat (8) tick();
  endtask

  // Bouncing input never settles; a steady hold then yields exactly one hit.
  task automatic test_bounce();
    int h0 = hit_seen;
    int m0 = miss_seen;
    set_light(4);
    tick();
    for (int s = 0; s < 10; s++) begin
      buttons[4] = (s % 2 == 0);
      repeat (2) tick();
    end
    repeat (2) tick();
    vectors++;
    if (hit_seen - h0 !== 0) begin
      miscompares++;
      $display("FAIL bounce_filtered: got %0d hits, want 0", hit_seen - h0);
    end
    buttons[4] = 1'b1;
    repeat (12) tick();
    exp_hit++;
    vectors++;
    if (hit_seen - h0 !== 1 || miss_seen - m0 !== 0 || hit_count !== 8'(exp_hit)) begin
      miscompares++;
      $display("FAIL bounce_then_steady: got hits=%0d misses=%0d hc=%0d, want 1 0 %0d",
               hit_seen - h0, miss_seen - m0, hit_count, exp_hit);
    end
    buttons[4] = 1'b0;
    clear_lights();
    repeat (8) tick();
  endtask

  // Light expires unpressed: one miss in the cycle after lights go 0, hit_pos kept.
  task automatic test_timeout();
    int m0 = miss_seen;
    set_light(7);
    repeat (30) tick();
    vectors++;
    if (miss_seen - m0 !== 0) begin
      miscompares++;
      $display("FAIL timeout_early: got %0d misses while lit, want 0", miss_seen - m0);
    end
    clear_lights();
    tick();
    exp_miss++;
    vectors++;
    if (miss !== 1'b1 || hit !== 1'b0 || hit_pos !== 4'd4 || miss_count !== 8'(exp_miss)) begin
      miscompares++;
      $display("FAIL timeout_miss: got miss=%0b hit=%0b pos=%0d mc=%0d, want 1 0 4 %0d",
               miss, hit, hit_pos, miss_count, exp_miss);
    end
    tick();
    vectors++;
    if (miss !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_pulse_width: got miss=%0b, want 0", miss);
    end
    repeat (3) tick();
  endtask

  // Lights jump to another hole without going dark: old flick times out.
  task automatic test_new_flick();
    set_light(1);
    repeat (4) tick();
    set_light(3);
    tick();
    exp_miss++;
    vectors++;
    if (miss !== 1'b1 || miss_count !== 8'(exp_miss)) begin
      miscompares++;
      $display("FAIL new_flick_miss: got miss=%0b mc=%0d, want 1 %0d", miss, miss_count, exp_miss);
    end
    tick();
    clear_lights();
    tick();
    exp_miss++;
    vectors++;
    if (miss !== 1'b1 || miss_count !== 8'(exp_miss)) begin
      miscompares++;
      $display("FAIL new_flick_rearmed: got miss=%0b mc=%0d, want 1 %0d", miss, miss_count, exp_miss);
    end
    repeat (3) tick();
  endtask

  // Disabling mid-flick drops to IDLE silently; tallies retained.
  task automatic test_enable();
    int m0;
    set_light(6);
    repeat (3) tick();
    m0 = miss_seen;
    enable = 1'b0;
    tick();
    clear_lights();
    repeat (4) tick();
    enable = 1'b1;
    repeat (2) tick();
    vectors++;
    if (miss_seen - m0 !== 0 || hit_count !== 8'(exp_hit) || miss_count !== 8'(exp_miss)) begin
      miscompares++;
      $display("FAIL enable_off: got misses=%0d hc=%0d mc=%0d, want 0 %0d %0d",
               miss_seen - m0, hit_count, miss_count, exp_hit, exp_miss);
    end
  endtask

  // Reset mid-debounce while ARMED: outputs clear at once, nothing emitted afterwards.
  task automatic test_reset_midflight();
    int h0, m0;
    set_light(5);
    tick();
    buttons[0] = 1'b1;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({hit, miss, hit_pos, hit_count, miss_count} !== 22'd0) begin
      miscompares++;
      $display("FAIL async_reset: got hit=%0b miss=%0b pos=%0d hc=%0d mc=%0d, want all 0",
               hit, miss, hit_pos, hit_count, miss_count);
    end
    buttons = '0;
    repeat (3) tick();
    h0 = hit_seen;
    m0 = miss_seen;
    reset = 1'b1;
    exp_hit  = 0;
    exp_miss = 0;
    repeat (20) tick();
    vectors++;
    if (hit_seen - h0 !== 0 || miss_seen - m0 !== 0 || hit_count !== 8'd0 || miss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_no_pulse: got hits=%0d misses=%0d hc=%0d mc=%0d, want all 0",
               hit_seen - h0, miss_seen - m0, hit_count, miss_count);
    end
  endtask

  task automatic one_hit();
    set_light(0);
    tick();
    buttons[0] = 1'b1;
    repeat (8) tick();
    buttons[0] = 1'b0;
    clear_lights();
    repeat (8) tick();
  endtask

  // 255 hits reach the ceiling; the 256th still pulses but does not wrap.
  task automatic test_saturate();
    int h0;
    apply_reset();
    h0 = hit_seen;
    for (int n = 0; n < 255; n++) one_hit();
    vectors++;
    if (hit_count !== 8'd255 || hit_seen - h0 !== 255) begin
      miscompares++;
      $display("FAIL hit_count_255: got hc=%0d pulses=%0d, want 255 255", hit_count, hit_seen - h0);
    end
    one_hit();
    vectors++;
    if (hit_count !== 8'd255 || hit_seen - h0 !== 256 || miss_count !== 8'd0) begin
      miscompares++;
      $display("FAIL hit_count_saturate: got hc=%0d pulses=%0d mc=%0d, want 255 256 0",
               hit_count, hit_seen - h0, miss_count);
    end
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    buttons   = '0;
    lights    = '0;
    light_pos = '0;
    test_reset();
    test_hit();
    test_wrong_press();
    test_bounce();
    test_timeout();
    test_new_flick();
    test_enable();
    test_reset_midflight();
    test_saturate();
    vectors++;
    if (both_seen !== 0) begin
      miscompares++;
      $display("FAIL hit_miss_exclusive: got %0d overlapping cycles, want 0", both_seen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
